// File: rtl/video_dram_arbiter_pkg.sv
// Shared definitions for the video DRAM arbiter slice.
//   owner_e   : who owns the current DRAM slot (NONE/VIDEO/CPU/RFSH)
//   BW_*      : video bandwidth codes driven on video_bw
//   ADDR_W    : DRAM word-address width
//   DATA_W    : DRAM data width
//   is_video_slot() : decodes whether a slot-counter value belongs to video
package video_dram_arbiter_pkg;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_CPU   = 2'd2,
        OWN_RFSH  = 2'd3
    } owner_e;

    localparam logic [1:0] BW_1_8 = 2'b00;
    localparam logic [1:0] BW_1_4 = 2'b01;
    localparam logic [1:0] BW_1_2 = 2'b10;
    localparam logic [1:0] BW_1_1 = 2'b11;

    function automatic logic is_video_slot(input logic [1:0] bw, input logic [2:0] slot);
        logic hit;
        case (bw)
            BW_1_8:  hit = (slot == 3'd0);
            BW_1_4:  hit = (slot[1:0] == 2'd0);
            BW_1_2:  hit = (slot[0] == 1'b0);
            default: hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/video_dram_arbiter_rfsh_ctr.sv
// Refresh divider plus saturating pending-refresh counter.
//   clk, rst_n : clock, async active-low reset
//   cend       : slot boundary pulse; advances the divider
//   take       : arbiter grants a refresh slot on this cend
//   pend_nz    : at least one refresh is pending
module video_dram_rfsh_ctr #(
    parameter int unsigned REFRESH_SLOTS = 64,
    parameter int unsigned RFSH_PEND_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cend,
    input  logic take,
    output logic pend_nz
);

    localparam int unsigned DIV_W  = $clog2(REFRESH_SLOTS);
    localparam int unsigned PEND_W = $clog2(RFSH_PEND_MAX + 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              tick;
    logic              dec;

    always_comb begin
        div_d  = div_q;
        pend_d = pend_q;
        tick   = cend && (div_q == DIV_W'(REFRESH_SLOTS - 1));
        dec    = cend && take && (pend_q != '0);
        if (cend) begin
            // Power-of-two period: natural wrap of the divider.
            div_d = div_q + 1'b1;
        end
        // New request and a grant on the same cend cancel out.
        if (tick && !dec) begin
            if (pend_q != PEND_W'(RFSH_PEND_MAX)) begin
                pend_d = pend_q + 1'b1;
            end
        end else if (dec && !tick) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            pend_q <= '0;
        end else begin
            div_q  <= div_d;
            pend_q <= pend_d;
        end
    end

    assign pend_nz = (pend_q != '0);

endmodule

// File: rtl/video_dram_arbiter.sv
// DRAM slot arbiter between video fetch, CPU and refresh.
//   cend/pre_cend       : slot framing (slot start / one clk before it)
//   video_go/bw/addr    : video fetch window, bandwidth share, fetch address
//   video_next/strobe   : address consumed / fetched word valid on video_data
//   cpu_req/rnw/addr/wdata : CPU request held until cpu_next
//   cpu_next/strobe     : request accepted / read word valid on cpu_rdata
//   dram_*              : per-slot command held for the whole slot; dram_rdata
//                         is valid at pre_cend of the slot after the access
module video_dram_arbiter
    import video_dram_arbiter_pkg::*;
#(
    parameter int unsigned REFRESH_SLOTS = 64,
    parameter int unsigned RFSH_PEND_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cend,
    input  logic              pre_cend,
    input  logic              video_go,
    input  logic [1:0]        video_bw,
    input  logic [ADDR_W-1:0] video_addr,
    output logic              video_next,
    output logic              video_strobe,
    output logic [DATA_W-1:0] video_data,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_next,
    output logic              cpu_strobe,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dram_req,
    output logic              dram_rnw,
    output logic              dram_rfsh,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic [DATA_W-1:0] dram_rdata
);

    typedef struct packed {
        logic              req;
        logic              rnw;
        logic              rfsh;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_cmd_t;

    logic [2:0]        slot_q, slot_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              last_rd_q, last_rd_d;
    slot_cmd_t         cmd_q, cmd_d;
    logic              video_next_q, video_next_d;
    logic              cpu_next_q, cpu_next_d;
    logic              video_strobe_q, video_strobe_d;
    logic              cpu_strobe_q, cpu_strobe_d;
    logic [DATA_W-1:0] video_data_q, video_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              take;
    logic              pend_nz;

    video_dram_rfsh_ctr #(
        .REFRESH_SLOTS (REFRESH_SLOTS),
        .RFSH_PEND_MAX (RFSH_PEND_MAX)
    ) u_rfsh_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .cend    (cend),
        .take    (take),
        .pend_nz (pend_nz)
    );

    always_comb begin
        slot_d         = slot_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        last_rd_d      = last_rd_q;
        cmd_d          = cmd_q;
        video_next_d   = 1'b0;
        cpu_next_d     = 1'b0;
        video_strobe_d = 1'b0;
        cpu_strobe_d   = 1'b0;
        video_data_d   = video_data_q;
        cpu_rdata_d    = cpu_rdata_q;
        take           = 1'b0;

        if (cend) begin
            slot_d       = slot_q + 3'd1;
            // The slot now ending becomes the one whose data returns next slot.
            last_owner_d = owner_q;
            last_rd_d    = cmd_q.req && cmd_q.rnw;
            cmd_d        = '0;
            if (video_go && is_video_slot(video_bw, slot_q)) begin
                owner_d      = OWN_VIDEO;
                cmd_d.req    = 1'b1;
                cmd_d.rnw    = 1'b1;
                cmd_d.addr   = video_addr;
                video_next_d = 1'b1;
            end else if (cpu_req) begin
                owner_d      = OWN_CPU;
                cmd_d.req    = 1'b1;
                cmd_d.rnw    = cpu_rnw;
                cmd_d.addr   = cpu_addr;
                cmd_d.wdata  = cpu_wdata;
                cpu_next_d   = 1'b1;
            end else if (pend_nz) begin
                owner_d      = OWN_RFSH;
                cmd_d.rfsh   = 1'b1;
                take         = 1'b1;
            end else begin
                owner_d      = OWN_NONE;
            end
        end

        if (pre_cend && last_rd_q) begin
            if (last_owner_q == OWN_VIDEO) begin
                video_data_d   = dram_rdata;
                video_strobe_d = 1'b1;
            end else if (last_owner_q == OWN_CPU) begin
                cpu_rdata_d    = dram_rdata;
                cpu_strobe_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q         <= '0;
            owner_q        <= OWN_NONE;
            last_owner_q   <= OWN_NONE;
            last_rd_q      <= 1'b0;
            cmd_q          <= '0;
            video_next_q   <= 1'b0;
            cpu_next_q     <= 1'b0;
            video_strobe_q <= 1'b0;
            cpu_strobe_q   <= 1'b0;
            video_data_q   <= '0;
            cpu_rdata_q    <= '0;
        end else begin
            slot_q         <= slot_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            last_rd_q      <= last_rd_d;
            cmd_q          <= cmd_d;
            video_next_q   <= video_next_d;
            cpu_next_q     <= cpu_next_d;
            video_strobe_q <= video_strobe_d;
            cpu_strobe_q   <= cpu_strobe_d;
            video_data_q   <= video_data_d;
            cpu_rdata_q    <= cpu_rdata_d;
        end
    end

    assign video_next   = video_next_q;
    assign video_strobe = video_strobe_q;
    assign video_data   = video_data_q;
    assign cpu_next     = cpu_next_q;
    assign cpu_strobe   = cpu_strobe_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dram_req     = cmd_q.req;
    assign dram_rnw     = cmd_q.rnw;
    assign dram_rfsh    = cmd_q.rfsh;
    assign dram_addr    = cmd_q.addr;
    assign dram_wdata   = cmd_q.wdata;

endmodule

// File: doc/video_dram_arbiter.md
Name: video_dram_arbiter

Overview:
- Allocates DRAM access slots between the video fetcher, the CPU and refresh.
- Sits directly upstream of the video output top: it drives that block's video_strobe and video_next, and consumes its video_addr, video_bw and video_go.
- Slots are framed by cend. Video takes a fixed fraction of slots, selected by video_bw. Remaining slots go to the CPU, otherwise to pending refresh.

Parameters:
REFRESH_SLOTS, 64, slots between refresh requests (power of two, 8..256).
RFSH_PEND_MAX, 3, saturation limit of the pending-refresh counter.

Ports:
clk  in  1  28 MHz clock
rst_n  in  1  async active-low reset
cend  in  1  one-clk pulse marking slot boundary (slot start)
pre_cend  in  1  one-clk pulse one clk before cend
video_go  in  1  video fetch window active
video_bw  in  2  00=1/8, 01=1/4, 10=1/2, 11=1/1 of slots
video_addr  in  21  word address of next video fetch
video_next  out  1  pulse: video_addr consumed, advance
video_strobe  out  1  pulse: video_data valid
video_data  out  16  fetched video word
cpu_req  in  1  CPU access request (level, held until cpu_next)
cpu_rnw  in  1  1=read, 0=write
cpu_addr  in  21  CPU word address
cpu_wdata  in  16  CPU write data
cpu_next  out  1  pulse: CPU request accepted
cpu_strobe  out  1  pulse: CPU read data valid
cpu_rdata  out  16  CPU read data
dram_req  out  1  access this slot
dram_rnw  out  1  slot direction
dram_rfsh  out  1  refresh this slot
dram_addr  out  21  slot address
dram_wdata  out  16  slot write data
dram_rdata  in  16  read data, valid at pre_cend of slot following the access

Behaviour:
- Reset: all outputs 0. Slot counter = 0. Refresh divider = 0. Pending = 0. Owner = NONE.
- Slot counter: 3 bits, incremented on every cend, wraps 7->0.
- Video slot is decided at cend using the counter value before the increment:
  - bw=00: slot==0
  - bw=01: slot[1:0]==0
  - bw=10: slot[0]==0
  - bw=11: always
  - in every case also requires video_go=1.
- Arbitration at each cend, in priority order:
  - video slot -> owner=VIDEO
  - else cpu_req -> owner=CPU
  - else pending>0 -> owner=RFSH, pending decrements
  - else owner=NONE.
- Video is never preempted. The CPU starves in bw=11 by design.
- Slot outputs are registered on the cend clock and held for the whole slot:
  - VIDEO: dram_req=1, dram_rnw=1, dram_addr=video_addr; video_next=1 for exactly this clk.
  - CPU: dram_req=1, rnw=cpu_rnw, addr=cpu_addr, wdata=cpu_wdata; cpu_next=1 for this clk.
  - RFSH: dram_rfsh=1, dram_req=0.
  - NONE: dram_req=0, dram_rfsh=0.
- Read return:
  - A 1-entry "last owner" register remembers the previous slot's owner and read flag.
  - At the pre_cend that ends the following slot, dram_rdata is captured into video_data or cpu_rdata.
  - video_strobe or cpu_strobe pulses on the next clk, which coincides with cend.
  - Latency: next pulse to strobe = 2 slots.
  - CPU writes produce no cpu_strobe.
- Refresh:
  - The divider counts cend pulses; every REFRESH_SLOTS it increments pending.
  - pending saturates at RFSH_PEND_MAX; the excess request is dropped.
  - A simultaneous increment and decrement leaves pending unchanged.
- video_go falling mid-window: a video slot already issued completes, and its strobe still fires. No new video slots are issued.
- video_bw changing: takes effect at the next cend. No glitch in a running slot.
- cend and pre_cend in the same clk: protocol violation, not handled.
- Reset mid-slot: outputs clear immediately (async). No strobe is issued for the aborted slot.

Decomposition:
- Shared package holds:
  - owner encoding (NONE=0, VIDEO=1, CPU=2, RFSH=3)
  - bandwidth code constants BW_1_8..BW_1_1
  - the 21-bit address width constant.
- One sub-module: video_dram_rfsh_ctr, the refresh divider plus pending saturating counter, with inputs cend and take and output pend_nz.

Test Plan:
- bw=00, video_go=1, cpu_req=0, REFRESH_SLOTS=64:
  - video_next fires at slot counts 0, 8, 16...
  - video_strobe follows 2 cends later with video_data = dram_rdata value 16'hA5A5.
  - exactly one dram_rfsh per 64 slots.
- bw=01, cpu_req held high:
  - owners repeat VIDEO, CPU, CPU, CPU.
  - cpu_next pulses 3 per 4 slots.
  - a CPU read to addr 21'h1F000 returns cpu_rdata=16'h1234 two slots after cpu_next.
- bw=11, video_go=1, cpu_req=1:
  - cpu_next never pulses.
  - pending refresh saturates at 3 and never exceeds it.
  - on video_go=0, the first non-video slot goes to CPU, the next three slots with no CPU request perform refresh.
- CPU write (cpu_rnw=0, wdata 16'hBEEF):
  - dram_rnw=0 and dram_wdata=16'hBEEF held for the whole slot.
  - no cpu_strobe.
- video_go drops one clk after a video cend:
  - that fetch still yields video_strobe.
  - no further video_next pulses.
- rst_n asserted mid-slot with owner=VIDEO:
  - all outputs 0 within the same clk.
  - no video_strobe afterwards.
  - after release, slot counter restarts at 0.
